// File: rtl/alu_result_fifo.sv
// alu_result_fifo: capture buffer for ALU result records.
// Records leave in arrival order through registered first-word-fall-through outputs.
// A capture that arrives while the FIFO is full (and is not paired with a pop) is dropped.
// Dropped captures set the sticky overflow flag.
// Optional macro ALU_FIFO_STATS_EN adds two saturating counters:
//   pushed_total counts accepted records, dropped_total counts dropped records.
module alu_result_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          result_ready,
  input  logic [7:0]    opcode_in,
  input  logic [7:0]    operand_a_in,
  input  logic [7:0]    operand_b_in,
  input  logic [7:0]    result_in,
  input  logic          carry_in,
  input  logic          borrow_in,
  input  logic [7:0]    pc_in,
  input  logic          next_out,
  output logic          out_valid,
  output logic [7:0]    out_opcode,
  output logic [7:0]    out_operand_a,
  output logic [7:0]    out_operand_b,
  output logic [7:0]    out_result,
  output logic          out_carry,
  output logic          out_borrow,
  output logic [7:0]    out_pc,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
`ifdef ALU_FIFO_STATS_EN
  output logic [15:0]   pushed_total,
  output logic [7:0]    dropped_total,
`endif
  output logic          overflow
);

  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       carry;
    logic       borrow;
    logic [7:0] pc;
  } rec_t;

  rec_t          mem [DEPTH];
  rec_t          wr_rec, head_q, head_d;
  logic [AW-1:0] wp, rp, rp_nxt;
  logic [AW:0]   cnt_after_pop, count_d;
  logic          do_push, do_pop, drop, vld_d;

  assign wr_rec = '{opcode: opcode_in, a: operand_a_in, b: operand_b_in, res: result_in,
                    carry: carry_in, borrow: borrow_in, pc: pc_in};

  // A pop in the same cycle frees a slot, so a full FIFO still accepts a paired push.
  assign do_pop  = next_out & out_valid;
  assign do_push = result_ready & (~full | do_pop);
  assign drop    = result_ready & full & ~do_pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  assign rp_nxt        = rp + {{(AW-1){1'b0}}, do_pop};
  assign cnt_after_pop = count - {{AW{1'b0}}, do_pop};
  assign count_d       = cnt_after_pop + {{AW{1'b0}}, do_push};

  // Storage array write; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wr_rec;
  end

  // Next head record.
  // An incoming record bypasses the array when it becomes the new head.
  // Otherwise, after a pop, the next stored entry is loaded.
  // When nothing remains, the last values are held.
  always_comb begin
    head_d = head_q;
    vld_d  = (count_d != '0);
    if (do_push && cnt_after_pop == '0)
      head_d = wr_rec;
    else if (do_pop && cnt_after_pop != '0)
      head_d = mem[rp_nxt];
  end

  // Pointers, occupancy, sticky overflow and registered head.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      head_q    <= '0;
    end else begin
      if (do_push) wp <= wp + {{(AW-1){1'b0}}, 1'b1};
      rp        <= rp_nxt;
      count     <= count_d;
      out_valid <= vld_d;
      head_q    <= head_d;
      if (drop) overflow <= 1'b1;
    end
  end

  assign out_opcode    = head_q.opcode;
  assign out_operand_a = head_q.a;
  assign out_operand_b = head_q.b;
  assign out_result    = head_q.res;
  assign out_carry     = head_q.carry;
  assign out_borrow    = head_q.borrow;
  assign out_pc        = head_q.pc;

`ifdef ALU_FIFO_STATS_EN
  // Saturating accept/drop counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pushed_total  <= '0;
      dropped_total <= '0;
    end else begin
      if (do_push && pushed_total != '1) pushed_total <= pushed_total + 16'd1;
      if (drop && dropped_total != '1)   dropped_total <= dropped_total + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Scoreboard bench for alu_result_fifo.
// The driver runs a queue-based reference model and pushes expected records.
// A negedge monitor checks the presented head and retires it on a pop.
module tb_alu_result_fifo;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       carry;
    logic       borrow;
    logic [7:0] pc;
  } rec_t;

  logic clk = 0, rst = 0;
  logic result_ready = 0, next_out = 0;
  logic [7:0] opcode_in = 0, operand_a_in = 0, operand_b_in = 0, result_in = 0, pc_in = 0;
  logic carry_in = 0, borrow_in = 0;
  logic out_valid, out_carry, out_borrow, full, empty, overflow;
  logic [7:0] out_opcode, out_operand_a, out_operand_b, out_result, out_pc;
  logic [AW:0] count;
`ifdef ALU_FIFO_STATS_EN
  logic [15:0] pushed_total;
  logic [7:0]  dropped_total;
  int m_pushed = 0, m_dropped = 0;
`endif

  alu_result_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .result_ready(result_ready),
    .opcode_in(opcode_in), .operand_a_in(operand_a_in), .operand_b_in(operand_b_in),
    .result_in(result_in), .carry_in(carry_in), .borrow_in(borrow_in), .pc_in(pc_in),
    .next_out(next_out), .out_valid(out_valid), .out_opcode(out_opcode),
    .out_operand_a(out_operand_a), .out_operand_b(out_operand_b), .out_result(out_result),
    .out_carry(out_carry), .out_borrow(out_borrow), .out_pc(out_pc),
    .count(count), .full(full), .empty(empty),
`ifdef ALU_FIFO_STATS_EN
    .pushed_total(pushed_total), .dropped_total(dropped_total),
`endif
    .overflow(overflow));

  always #5 clk = ~clk;

  int   checks = 0, passes = 0;
  rec_t sb_q[$];
  int   m_cnt = 0;
  bit   m_ovf = 0;
  rec_t last_rec = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic rec_t mk(input logic [7:0] op, a, b, r, input logic c, bo, input logic [7:0] pc);
    rec_t x;
    x.opcode = op; x.a = a; x.b = b; x.res = r; x.carry = c; x.borrow = bo; x.pc = pc;
    return x;
  endfunction

  function automatic rec_t rnd_rec();
    return mk($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
              $urandom_range(0, 255), $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 255));
  endfunction

  // Monitor: compare the presented head with the oldest expected record, retire on pop.
  always @(negedge clk) begin
    rec_t got;
    got = mk(out_opcode, out_operand_a, out_operand_b, out_result, out_carry, out_borrow, out_pc);
    if (rst) begin
      if (out_valid) begin
        if (sb_q.size() == 0) chk("head_unexpected", 1, 0);
        else begin
          chk("head_rec", got, sb_q[0]);
          if (next_out) begin
            last_rec = sb_q.pop_front();
          end
        end
      end else begin
        chk("hold_rec", got, last_rec);
      end
    end
  end

  // Flag and occupancy checks against the reference model.
  task automatic flags();
    chk("count", count, m_cnt);
    chk("full", full, m_cnt == DEPTH);
    chk("empty", empty, m_cnt == 0);
    chk("out_valid", out_valid, m_cnt != 0);
    chk("overflow", overflow, m_ovf);
`ifdef ALU_FIFO_STATS_EN
    chk("pushed_total", pushed_total, m_pushed);
    chk("dropped_total", dropped_total, m_dropped);
`endif
  endtask

  // One clock of stimulus.
  // The reference model is updated first, then the edge passes and the flags are checked.
  task automatic cyc(input logic rr, input rec_t r, input logic nx);
    bit pop, push;
    result_ready = rr; next_out = nx;
    opcode_in = r.opcode; operand_a_in = r.a; operand_b_in = r.b; result_in = r.res;
    carry_in = r.carry; borrow_in = r.borrow; pc_in = r.pc;
    pop  = nx && m_cnt > 0;
    push = rr && (m_cnt < DEPTH || pop);
    if (push) sb_q.push_back(r);
    m_cnt += int'(push) - int'(pop);
    if (rr && !push) m_ovf = 1;
`ifdef ALU_FIFO_STATS_EN
    if (push && m_pushed < 65535) m_pushed++;
    if (rr && !push && m_dropped < 255) m_dropped++;
`endif
    @(posedge clk); #1;
    flags();
  endtask

  task automatic do_reset();
    result_ready = 0; next_out = 0;
    rst = 0; #1;
    sb_q.delete(); m_cnt = 0; m_ovf = 0; last_rec = '0;
`ifdef ALU_FIFO_STATS_EN
    m_pushed = 0; m_dropped = 0;
`endif
    flags();
    chk("rst_out_result", out_result, 0);
    @(negedge clk); @(posedge clk); #1;
    rst = 1;
  endtask

  initial begin
    rec_t z;
    z = '0;
    // Reset state.
    #2;
    do_reset();

    // Single capture and pop.
    cyc(1, mk(8'h01, 8'd5, 8'd3, 8'd8, 0, 0, 8'd0), 0);
    chk("first_result", out_result, 8);
    cyc(0, z, 1);

    // Fill, overflow on a ninth record, then drain in order.
    for (int i = 1; i <= 8; i++) cyc(1, mk(8'h02, 0, 0, 8'(i), 0, 0, 8'(i)), 0);
    cyc(1, mk(8'h02, 0, 0, 8'd9, 0, 0, 8'd9), 0);
    for (int i = 0; i < 8; i++) cyc(0, z, 1);

    // A paired push and pop while full does not drop the record.
    do_reset();
    for (int i = 1; i <= 8; i++) cyc(1, mk(8'h03, 0, 0, 8'(i), 0, 0, 8'(i)), 0);
    cyc(1, mk(8'h03, 0, 0, 8'd20, 0, 0, 8'd20), 1);
    for (int i = 0; i < 7; i++) cyc(0, z, 1);
    chk("last_is_20", out_result, 20);
    cyc(0, z, 1);
    chk("last_read_20", last_rec.res, 20);

    // Pops on an empty FIFO are ignored; a negative result is kept as its byte pattern.
    for (int i = 0; i < 10; i++) cyc(0, z, 1);
    cyc(1, mk(8'h04, 0, 0, 8'hF9, 1, 1, 8'h33), 0);
    chk("neg_result", out_result, 8'hF9);
    cyc(0, z, 1);

    // Wrap-around: a push per cycle while the head pops, keeping one record in flight.
    cyc(1, mk(8'h05, 0, 0, 0, 0, 0, 8'd0), 0);
    for (int i = 1; i < 20; i++) begin
      cyc(1, mk(8'h05, 0, 0, 0, 0, 0, 8'(i)), 1);
      chk("pc_follow", out_pc, i);
    end
    cyc(0, z, 1);

    // Randomized traffic in phases with different push and pop densities.
    for (int ph = 0; ph < 4; ph++)
      for (int i = 0; i < 120; i++)
        cyc($urandom_range(0, 3) < 3 - ph % 3, rnd_rec(), $urandom_range(0, 3) < 1 + ph);

    // Asynchronous reset with five records stored.
    do_reset();
    for (int i = 0; i < 9; i++) cyc(1, rnd_rec(), 0);
    for (int i = 0; i < 3; i++) cyc(0, z, 1);
    chk("pre_rst_count", count, 5);
    @(negedge clk); #2;
    do_reset();
    cyc(1, mk(8'h06, 1, 2, 3, 0, 1, 8'd7), 0);
    cyc(0, z, 1);

    chk("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
Downstream capture buffer for the 8-bit ALU cpu. On each result_ready strobe it records the whole result record: opcode, both operands, result, carry, borrow and pc. It presents the records in arrival order to a slow consumer, such as a display or host reader, which pops them with a next_out request. This decouples cpu execution rate from readout rate and flags lost records.

Parameters:
DEPTH, 8, number of stored records; power of two, 2..256
AW, 3, pointer width, log2(DEPTH)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset (0 = reset asserted)
result_ready  input  1  capture strobe from cpu; one record per high cycle
opcode_in  input  8  cpu opcode
operand_a_in  input  8  signed operand A
operand_b_in  input  8  signed operand B
result_in  input  8  signed result
carry_in  input  1  carry flag
borrow_in  input  1  borrow flag
pc_in  input  8  cpu program counter
next_out  input  1  consumer pop request
out_valid  output  1  head record present on out_* ports
out_opcode  output  8  head opcode
out_operand_a  output  8  head operand A
out_operand_b  output  8  head operand B
out_result  output  8  head result
out_carry  output  1  head carry
out_borrow  output  1  head borrow
out_pc  output  8  head pc
count  output  AW+1  records stored, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
overflow  output  1  sticky: a record was dropped

Behaviour:
- Storage: DEPTH x 42-bit record array, plus write pointer wp, read pointer rp and count register. Pointers wrap modulo DEPTH.
- Reset (rst low, asynchronous): wp=rp=0, count=0, overflow=0, out_valid=0, all out_* data=0, empty=1, full=0. The array contents need no reset.
- Reset mid-operation discards all stored records. The first capture after rst rises is stored at index 0.
- Push: result_ready=1 and (not full, or a pop in the same cycle). The record is written at wp on the rising edge, then wp++.
- Pop: next_out=1 and out_valid=1. On the edge, rp++.
- next_out while empty is ignored: no pointer or count change, no error.
- Simultaneous push and pop:
  - Both take effect and count is unchanged.
  - This also applies when full, so no drop occurs.
  - When count=1 the head advances to the new record and out_valid stays 1.
- Push while full without a pop: the record is dropped, overflow is set to 1, and pointers and count are unchanged. overflow clears only on reset.
- count: +1 on push only, -1 on pop only, unchanged otherwise.
- Output timing is first-word-fall-through with registered outputs.
  - out_valid and out_* update on the same edge as the push or pop.
  - A record pushed into an empty FIFO appears on out_* with out_valid=1 in the cycle after the result_ready edge (latency 1).
  - After a pop, the next record appears in the following cycle. If none remains, out_valid=0 and out_* hold their last values.
- The consumer reads out_* while out_valid=1. The record is retired on the first clk edge with next_out=1.
- full and empty are combinational decodes of count, and are consistent with count in every cycle.

Optional Feature:
ALU_FIFO_STATS_EN:
- When defined, two extra output ports exist:
  - pushed_total [15:0]: counts accepted records.
  - dropped_total [7:0]: counts dropped records.
- Both counters reset to 0 and saturate at all-ones; they never wrap.
- When not defined, these ports and counters are absent, and the remaining behaviour is identical.

Test Plan:
- Reset then one capture (op=8'h01, A=5, B=3, result=8, carry=0, borrow=0, pc=0) -> next cycle out_valid=1, out_result=8, count=1. Pulse next_out -> out_valid=0, empty=1.
- Push 8 records with result=1..8 and no pops -> full=1, count=8, overflow=0. A 9th push (result=9) -> overflow=1, count=8. Drain -> results 1..8 in order, 9 absent, empty=1.
- With full=1, push result=20 and pop in the same cycle -> count stays 8, overflow stays 0. After a full drain the last record read has result=20.
- Hold next_out=1 continuously on an empty FIFO for 10 cycles -> count=0, rp unchanged. A later push result=-7 -> out_result=8'hF9, out_valid=1.
- Wrap-around: do 20 interleaved push/pop pairs with pc=0..19 -> out_pc follows 0..19 in order, count never exceeds 1.
- Assert rst low mid-stream with count=5 -> count=0, out_valid=0, overflow=0 immediately, without waiting for a clock. With ALU_FIFO_STATS_EN, also pushed_total=0 and dropped_total=0.
